countdown_timer: RTL and testbench

Down-counting mm:ss timer: the decrementing counterpart of the 0..59 wrap-around up counter used in the clock datapath. It takes a load value for minutes and seconds, divides `clk` into one-second ticks, and borrows from minutes when seconds pass 00. It stops at 00:00 and signals expiry to the display/alarm logic. Everything runs in one clock domain; the displayed value comes straight from the `minutes` and `seconds` registers.

---
 rtl/countdown_timer_if.sv | 29 ++
 rtl/countdown_timer.sv | 127 ++++++++++++
 tb/tb_countdown_timer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control and display bundle for the mm:ss countdown timer.
// Ports: load/load_min/load_sec/start/pause travel from controller to timer;
//        minutes/seconds/running/expired/done travel from timer to display/alarm.
interface countdown_timer_if #(
  parameter int OUT_WIDTH = 6
);
  logic                 load;
  logic [OUT_WIDTH-1:0] load_min;
  logic [OUT_WIDTH-1:0] load_sec;
  logic                 start;
  logic                 pause;
  logic [OUT_WIDTH-1:0] minutes;
  logic [OUT_WIDTH-1:0] seconds;
  logic                 running;
  logic                 expired;
  logic                 done;

  // Controller side: issues commands, observes the timer state.
  modport master (
    output load, load_min, load_sec, start, pause,
    input  minutes, seconds, running, expired, done
  );

  // Timer side.
  modport slave (
    input  load, load_min, load_sec, start, pause,
    output minutes, seconds, running, expired, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Down-counting mm:ss timer with pause/resume, stopping at 00:00 with a one-cycle done pulse.
// Latency: commands take effect on the sampling edge; first decrement TICK_DIV cycles after start.
// Backpressure: none; commands are sampled every cycle with priority rst > load > pause > start > tick.
// Ports: clk, rst (sync, active-high); bus (slave) carries load/load_min/load_sec/start/pause
//        in and registered minutes/seconds/running/expired/done out.
module countdown_timer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int OUT_WIDTH = 6,
  parameter int MAX_MIN   = 59
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]        TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [OUT_WIDTH-1:0] SEC_MAX   = OUT_WIDTH'(59);
  localparam logic [OUT_WIDTH-1:0] MIN_MAX   = OUT_WIDTH'(MAX_MIN);
  localparam logic [OUT_WIDTH-1:0] ONE       = OUT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t               state_q, state_d;
  logic [OUT_WIDTH-1:0] min_q, min_d;
  logic [OUT_WIDTH-1:0] sec_q, sec_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 done_q, done_d;
  logic                 running_q, expired_q;

  logic [OUT_WIDTH-1:0] min_sat, sec_sat;
  logic                 is_zero;

  assign min_sat = (bus.load_min > MIN_MAX) ? MIN_MAX : bus.load_min;
  assign sec_sat = (bus.load_sec > SEC_MAX) ? SEC_MAX : bus.load_sec;
  assign is_zero = (min_q == '0) && (sec_q == '0);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          min_d   = min_sat;
          sec_d   = sec_sat;
          presc_d = '0;
        end else if (!bus.pause && bus.start && !is_zero) begin
          // pause alongside start suppresses the start here
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        // load is ignored while running; the pause edge never decrements
        if (bus.pause) begin
          state_d = PAUSED;
        end else if (is_zero) begin
          state_d = EXPIRED;
        end else if (presc_q == TICK_LAST) begin
          presc_d = '0;
          if (sec_q != '0) begin
            sec_d = sec_q - ONE;
          end else begin
            sec_d = SEC_MAX;
            min_d = min_q - ONE;
          end
          if ((min_q == '0) && (sec_q == ONE)) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSED: begin
        if (bus.load) begin
          state_d = IDLE;
          min_d   = min_sat;
          sec_d   = sec_sat;
          presc_d = '0;
        end else if (!bus.pause && bus.start) begin
          // prescaler kept so the partial second carries over
          state_d = RUN;
        end
      end
      EXPIRED: begin
        if (bus.load) begin
          state_d = IDLE;
          min_d   = min_sat;
          sec_d   = sec_sat;
          presc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == EXPIRED);
    end
  end

  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.running = running_q;
  assign bus.expired = expired_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4: expected outputs are queued as each
// stimulus step is driven and popped/compared one cycle later on the falling edge.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_if #(.OUT_WIDTH(6)) bus ();

  countdown_timer #(
    .TICK_DIV (4),
    .OUT_WIDTH(6),
    .MAX_MIN  (59)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      tag;
    logic [5:0] m;
    logic [5:0] s;
    logic       run;
    logic       exp;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Queue the expectation for this step, let one clock edge pass, then compare.
  task automatic cyc(input string tag, input int m, input int s,
                     input logic run, input logic exp, input logic dn);
    exp_t e;
    e.tag = tag; e.m = 6'(m); e.s = 6'(s); e.run = run; e.exp = exp; e.dn = dn;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".minutes"}, 32'(bus.minutes), 32'(e.m));
      chk({e.tag, ".seconds"}, 32'(bus.seconds), 32'(e.s));
      chk({e.tag, ".running"}, 32'(bus.running), 32'(e.run));
      chk({e.tag, ".expired"}, 32'(bus.expired), 32'(e.exp));
      chk({e.tag, ".done"},    32'(bus.done),    32'(e.dn));
    end
  endtask

  task automatic set_load(input logic l, input int m, input int s);
    bus.load     = l;
    bus.load_min = 6'(m);
    bus.load_sec = 6'(s);
  endtask

  initial begin
    bus.load = 1'b0; bus.load_min = '0; bus.load_sec = '0;
    bus.start = 1'b0; bus.pause = 1'b0;

    // reset
    rst = 1'b1;
    cyc("rst_a", 0, 0, 0, 0, 0);
    cyc("rst_b", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // load
    set_load(1, 1, 5); cyc("load_0105", 1, 5, 0, 0, 0); set_load(0, 0, 0);
    cyc("hold_0105", 1, 5, 0, 0, 0);

    // borrow from minutes
    set_load(1, 1, 0); cyc("load_0100", 1, 0, 0, 0, 0); set_load(0, 0, 0);
    bus.start = 1'b1; cyc("start_0100", 1, 0, 1, 0, 0); bus.start = 1'b0;
    for (int i = 0; i < 3; i++) cyc("pre_borrow", 1, 0, 1, 0, 0);
    cyc("borrow_0059", 0, 59, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc("wait_0058", 0, 59, 1, 0, 0);
    cyc("dec_0058", 0, 58, 1, 0, 0);
    bus.pause = 1'b1; cyc("pause_0058", 0, 58, 0, 0, 0); bus.pause = 1'b0;

    // expiry
    set_load(1, 0, 2); cyc("load_0002", 0, 2, 0, 0, 0); set_load(0, 0, 0);
    bus.start = 1'b1; cyc("start_0002", 0, 2, 1, 0, 0); bus.start = 1'b0;
    for (int i = 0; i < 3; i++) cyc("run_0002", 0, 2, 1, 0, 0);
    cyc("dec_0001", 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc("run_0001", 0, 1, 1, 0, 0);
    cyc("expire", 0, 0, 0, 1, 1);
    cyc("done_once", 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) cyc("exp_hold", 0, 0, 0, 1, 0);
    bus.start = 1'b1; cyc("start_in_exp", 0, 0, 0, 1, 0); bus.start = 1'b0;
    cyc("exp_after_start", 0, 0, 0, 1, 0);

    // pause and resume with partial second preserved (prescaler frozen at 2)
    set_load(1, 0, 3); cyc("load_0003", 0, 3, 0, 0, 0); set_load(0, 0, 0);
    bus.start = 1'b1; cyc("start_0003", 0, 3, 1, 0, 0); bus.start = 1'b0;
    for (int i = 0; i < 2; i++) cyc("run_0003", 0, 3, 1, 0, 0);
    bus.pause = 1'b1; cyc("pause_0003", 0, 3, 0, 0, 0); bus.pause = 1'b0;
    for (int i = 0; i < 10; i++) cyc("frozen_0003", 0, 3, 0, 0, 0);
    bus.start = 1'b1; bus.pause = 1'b1; cyc("both_in_pause", 0, 3, 0, 0, 0);
    bus.pause = 1'b0; cyc("resume", 0, 3, 1, 0, 0); bus.start = 1'b0;
    cyc("resume_p3", 0, 3, 1, 0, 0);
    cyc("resume_tick", 0, 2, 1, 0, 0);

    // load during RUN is ignored
    set_load(1, 0, 9); cyc("load_in_run", 0, 2, 1, 0, 0); set_load(0, 0, 0);

    // reset on the edge that would expire: pending done dropped
    bus.pause = 1'b1; cyc("pause2", 0, 2, 0, 0, 0); bus.pause = 1'b0;
    set_load(1, 0, 1); cyc("load_0001", 0, 1, 0, 0, 0); set_load(0, 0, 0);
    bus.start = 1'b1; cyc("start_0001", 0, 1, 1, 0, 0); bus.start = 1'b0;
    for (int i = 0; i < 3; i++) cyc("run_last", 0, 1, 1, 0, 0);
    rst = 1'b1; cyc("rst_mid", 0, 0, 0, 0, 0); rst = 1'b0;
    cyc("no_done_after_rst", 0, 0, 0, 0, 0);

    // start at 00:00 from IDLE is ignored
    bus.start = 1'b1; cyc("start_zero", 0, 0, 0, 0, 0); bus.start = 1'b0;
    for (int i = 0; i < 3; i++) cyc("idle_zero", 0, 0, 0, 0, 0);

    // saturation on load
    set_load(1, 63, 63); cyc("sat_5959", 59, 59, 0, 0, 0);
    set_load(1, 10, 60); cyc("sat_sec", 10, 59, 0, 0, 0);
    set_load(1, 60, 30); cyc("sat_min", 59, 30, 0, 0, 0);
    set_load(0, 0, 0);

    // start with pause in IDLE: neither acts
    bus.start = 1'b1; bus.pause = 1'b1; cyc("both_idle", 59, 30, 0, 0, 0);
    bus.start = 1'b0; bus.pause = 1'b0;
    cyc("idle_after_both", 59, 30, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
